// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: 32-step shift-add / restoring shift-subtract
// on unsigned magnitudes, followed by a sign-fixup cycle and a held response.
module alu_muldiv_seq #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Private 32-bit adder/subtractor; bit 32 is carry-out (for SUB: 1 means no borrow).
    function automatic logic [32:0] alu32(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] b_opnd;
        b_opnd = (op == ALU_SUB) ? ~b : b;
        return {1'b0, a} + {1'b0, b_opnd} + {32'd0, op};
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        b_zero_q, b_zero_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rsp_result_q, rsp_result_d;

    logic        accept;
    logic        a_signed, b_signed;
    logic        req_sign_a, req_sign_b;
    logic [31:0] req_a_mag, req_b_mag;
    logic        div_by_zero, div_overflow, special;
    logic [31:0] special_result;
    logic        is_div;
    logic        alu_op;
    logic [31:0] alu_a, alu_b;
    logic [32:0] alu_out;
    logic        div_take;
    logic [63:0] mul_step, div_step;
    logic [63:0] prod_fixed;
    logic [31:0] quot_fixed, rem_fixed;
    logic [31:0] fix_result;

    // Request decode: signedness per funct3 and the RISC-V defined special cases.
    always_comb begin
        a_signed       = ~req_op[0] | (req_op == 3'd1);
        b_signed       = a_signed & (req_op != 3'd2);
        req_sign_a     = a_signed & req_a[31];
        req_sign_b     = b_signed & req_b[31];
        req_a_mag      = req_sign_a ? -req_a : req_a;
        req_b_mag      = req_sign_b ? -req_b : req_b;
        div_by_zero    = req_op[2] & (req_b == 32'd0);
        div_overflow   = req_op[2] & ~req_op[0] & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);
        special        = div_by_zero | div_overflow;
        special_result = 32'd0;
        if (div_by_zero) begin
            special_result = req_op[1] ? req_a : 32'hFFFF_FFFF;
        end else if (div_overflow) begin
            special_result = req_op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    assign accept = (state_q == S_IDLE) & req_valid & ~flush;

    // One iteration step; the single adder is shared between multiply and divide.
    always_comb begin
        is_div   = op_q[2];
        alu_op   = is_div ? ALU_SUB : ALU_ADD;
        alu_a    = is_div ? {acc_q[62:32], acc_q[31]} : acc_q[63:32];
        alu_b    = is_div ? b_mag_q : a_mag_q;
        alu_out  = alu32(alu_op, alu_a, alu_b);
        mul_step = acc_q[0] ? {alu_out[32], alu_out[31:0], acc_q[31:1]} : {1'b0, acc_q[63:1]};
        // The bit shifted out of the remainder counts toward the trial compare.
        div_take = acc_q[63] | alu_out[32];
        div_step = div_take ? {alu_out[31:0], acc_q[30:0], 1'b1}
                            : {alu_a, acc_q[30:0], 1'b0};
    end

    // Sign fixup and result selection; a zero divisor keeps the all-ones quotient.
    always_comb begin
        prod_fixed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fixed = ((sign_a_q ^ sign_b_q) & ~b_zero_q) ? -acc_q[31:0] : acc_q[31:0];
        rem_fixed  = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
        case (op_q)
            3'd0:       fix_result = prod_fixed[31:0];
            3'd1, 3'd2,
            3'd3:       fix_result = prod_fixed[63:32];
            3'd4, 3'd5: fix_result = quot_fixed;
            default:    fix_result = rem_fixed;
        endcase
    end

    always_comb begin
        op_d         = op_q;
        a_mag_d      = a_mag_q;
        b_mag_d      = b_mag_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        b_zero_d     = b_zero_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        if (accept) begin
            op_d     = req_op;
            a_mag_d  = req_a_mag;
            b_mag_d  = req_b_mag;
            sign_a_d = req_sign_a;
            sign_b_d = req_sign_b;
            b_zero_d = (req_b == 32'd0);
            acc_d    = {32'd0, req_op[2] ? req_a_mag : req_b_mag};
            cnt_d    = 5'd31;
            if (EARLY_OUT && special) begin
                rsp_result_d = special_result;
            end
        end else if (!flush && state_q == S_CALC) begin
            acc_d = is_div ? div_step : mul_step;
            if (cnt_q != 5'd0) begin
                cnt_d = cnt_q - 5'd1;
            end
        end else if (!flush && state_q == S_FIX) begin
            rsp_result_d = fix_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= 3'd0;
            a_mag_q      <= 32'd0;
            b_mag_q      <= 32'd0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            b_zero_q     <= 1'b0;
            acc_q        <= 64'd0;
            cnt_q        <= 5'd0;
            rsp_result_q <= 32'd0;
        end else begin
            op_q         <= op_d;
            a_mag_q      <= a_mag_d;
            b_mag_q      <= b_mag_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            b_zero_q     <= b_zero_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) state_d = (EARLY_OUT && special) ? S_DONE : S_CALC;
                S_CALC: if (cnt_q == 5'd0) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: if (rsp_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
    end

    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: one early-out and one fully iterative instance share
// the request/response stimulus, and both are checked against hand-computed results.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic        req_ready_e, rsp_valid_e;
    logic [31:0] rsp_result_e;
    logic        req_ready_f, rsp_valid_f;
    logic [31:0] rsp_result_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.EARLY_OUT(1'b1)) dut_e (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready_e),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid_e),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result_e)
    );

    alu_muldiv_seq #(.EARLY_OUT(1'b0)) dut_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready_f),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid_f),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op to both instances, wait for both responses, optionally stall, then hand off.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_e,
                          input int hold);
        int cyc;
        int got_lat_e;
        int got_lat_f;
        logic [31:0] res_e;
        logic [31:0] res_f;
        cyc = 0;
        got_lat_e = 0;
        got_lat_f = 0;
        res_e = 32'd0;
        res_f = 32'd0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_a     = $urandom;
        req_b     = $urandom;
        cyc = 1;
        check({tag, "_ready_e"}, {31'd0, req_ready_e}, 32'd0);
        check({tag, "_ready_f"}, {31'd0, req_ready_f}, 32'd0);
        while ((got_lat_e == 0 || got_lat_f == 0) && cyc < 100) begin
            if (rsp_valid_e && got_lat_e == 0) begin
                got_lat_e = cyc;
                res_e = rsp_result_e;
            end
            if (rsp_valid_f && got_lat_f == 0) begin
                got_lat_f = cyc;
                res_f = rsp_result_f;
            end
            if (got_lat_e == 0 || got_lat_f == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_lat_e"}, 32'(got_lat_e), 32'(lat_e));
        check({tag, "_lat_f"}, 32'(got_lat_f), 32'd34);
        check({tag, "_res_e"}, res_e, exp);
        check({tag, "_res_f"}, res_f, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, rsp_valid_e}, 32'd1);
            check({tag, "_hold_res"}, rsp_result_e, exp);
            check({tag, "_hold_ready"}, {31'd0, req_ready_e}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, {30'd0, rsp_valid_e, rsp_valid_f}, 32'd0);
        check({tag, "_post_ready"}, {30'd0, req_ready_e, req_ready_f}, 32'd3);
        $display("%s: op=%0d a=%h b=%h result=%h/%h lat=%0d/%0d", tag, op, a, b,
                 res_e, res_f, got_lat_e, got_lat_f);
    endtask

    initial begin
        int rises;
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {30'd0, req_ready_e, req_ready_f}, 32'd3);
        check("rst_valid", {30'd0, rsp_valid_e, rsp_valid_f}, 32'd0);
        check("rst_res_e", rsp_result_e, 32'd0);
        check("rst_res_f", rsp_result_f, 32'd0);
        rst_n = 1'b1;

        run_op("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 10);
        run_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 0);
        run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
        run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
        run_op("divu",    3'd5, 32'd100,       32'd7,         32'd14,        34, 0);
        run_op("remu",    3'd7, 32'd100,       32'd7,         32'd2,         34, 0);
        run_op("divu_z",  3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1,  0);
        run_op("remu_z",  3'd7, 32'd100,       32'd0,         32'h0000_0064, 1,  0);
        run_op("div_z",   3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  0);
        run_op("rem_z",   3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
        run_op("divu_big",3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         34, 0);
        run_op("remu_big",3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, 0);

        // Flush mid-iteration (counter at 15), with a competing request in the flush cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd9;
        req_b     = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (16) @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_ready", {30'd0, req_ready_e, req_ready_f}, 32'd3);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid_e || rsp_valid_f) rises++;
        end
        check("flush_no_valid", 32'(rises), 32'd0);
        $display("flush: aborted MUL 9*9, rsp_valid rises=%0d", rises);
        run_op("mul_post_flush", 3'd0, 32'd3, 32'd5, 32'd15, 34, 0);

        // Reset in the middle of an op clears the held result as well.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd11;
        req_b     = 32'd13;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", {30'd0, req_ready_e, req_ready_f}, 32'd3);
        check("midrst_res_e", rsp_result_e, 32'd0);
        check("midrst_res_f", rsp_result_f, 32'd0);
        $display("midrst: result=%h/%h", rsp_result_e, rsp_result_f);
        run_op("mul_post_rst", 3'd0, 32'd11, 32'd13, 32'd143, 34, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
